// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module : alu_pkg
// Brief  : Shared ALU function codes, data width and multiply-sequencer states.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] FN_AND = 4'b0000;
   localparam logic [3:0] FN_OR  = 4'b0001;
   localparam logic [3:0] FN_ADD = 4'b0010;
   localparam logic [3:0] FN_SUB = 4'b0110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
//------------------------------------------------------------------------------
// Module : alu_mul_seq
// Brief  : Multi-cycle unsigned 32x32 shift-and-add multiplier (MUL/MULHU) that
//          borrows the shared ALU adder; optional early-out via MUL_EARLY_OUT_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic [XLEN-1:0] i_req_a,
   input  logic [XLEN-1:0] i_req_b,
   input  logic            i_req_hi,
   output logic            o_alu_req,
   input  logic            i_alu_gnt,
   output logic [XLEN-1:0] o_alu_in1,
   output logic [XLEN-1:0] o_alu_in2,
   output logic [3:0]      o_alu_ctrl,
   input  logic [XLEN-1:0] i_alu_out,
   output logic            o_rsp_valid,
   input  logic            i_rsp_ready,
   output logic [XLEN-1:0] o_rsp_data
);

   mul_state_t       r_state;
   logic [XLEN-1:0]  r_mcand;
   logic [XLEN-1:0]  r_hi;
   logic [XLEN-1:0]  r_lo;
   logic             r_sel;
   logic [CNT_W-1:0] r_cnt;
   logic             r_req_ready;
   logic             r_alu_req;
   logic             r_rsp_valid;
   logic [XLEN-1:0]  r_rsp_data;

   logic             w_step;
   logic             w_last;
   logic             w_carry;
   logic [XLEN-1:0]  w_sum;
   logic [XLEN-1:0]  w_hi_step;
   logic [XLEN-1:0]  w_lo_step;

   assign o_req_ready = r_req_ready;
   assign o_alu_req   = r_alu_req;
   assign o_alu_in1   = r_mcand;
   assign o_alu_in2   = r_hi;
   assign o_alu_ctrl  = FN_ADD;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data  = r_rsp_data;

   // The ALU sum wraps at 32 bits; it is smaller than hi exactly when it overflowed.
   assign w_step    = (r_state == RUN) && r_alu_req && i_alu_gnt;
   assign w_last    = (r_cnt == CNT_W'(XLEN - 1));
   assign w_sum     = r_lo[0] ? i_alu_out : r_hi;
   assign w_carry   = r_lo[0] && (i_alu_out < r_hi);
   assign w_hi_step = {w_carry, w_sum[XLEN-1:1]};
   assign w_lo_step = {w_sum[0], r_lo[XLEN-1:1]};

`ifdef MUL_EARLY_OUT_EN
   logic [XLEN-1:0]   r_mrem;
   logic              w_skip;
   logic [CNT_W:0]    w_shamt;
   logic [2*XLEN-1:0] w_skip_val;

   assign w_skip     = (r_state == RUN) && (r_mrem == '0);
   assign w_shamt    = (CNT_W+1)'(XLEN) - {1'b0, r_cnt};
   assign w_skip_val = {r_hi, r_lo} >> w_shamt;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_mcand     <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_sel       <= 1'b0;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_alu_req   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
`ifdef MUL_EARLY_OUT_EN
         r_mrem      <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (i_req_valid && r_req_ready) begin
                  r_mcand     <= i_req_a;
                  r_lo        <= i_req_b;
                  r_hi        <= '0;
                  r_sel       <= i_req_hi;
                  r_cnt       <= '0;
                  r_req_ready <= 1'b0;
                  r_state     <= RUN;
`ifdef MUL_EARLY_OUT_EN
                  r_mrem      <= i_req_b;
                  r_alu_req   <= (i_req_b != '0);
`else
                  r_alu_req   <= 1'b1;
`endif
               end else begin
                  r_req_ready <= 1'b1;
               end
            end

            RUN: begin
`ifdef MUL_EARLY_OUT_EN
               if (w_skip) begin
                  r_hi        <= w_skip_val[2*XLEN-1:XLEN];
                  r_lo        <= w_skip_val[XLEN-1:0];
                  r_rsp_data  <= r_sel ? w_skip_val[2*XLEN-1:XLEN] : w_skip_val[XLEN-1:0];
                  r_rsp_valid <= 1'b1;
                  r_alu_req   <= 1'b0;
                  r_state     <= DONE;
               end else
`endif
               if (w_step) begin
                  r_hi  <= w_hi_step;
                  r_lo  <= w_lo_step;
                  r_cnt <= r_cnt + CNT_W'(1);
`ifdef MUL_EARLY_OUT_EN
                  r_mrem <= r_mrem >> 1;
`endif
                  if (w_last) begin
                     r_rsp_data  <= r_sel ? w_hi_step : w_lo_step;
                     r_rsp_valid <= 1'b1;
                     r_alu_req   <= 1'b0;
                     r_state     <= DONE;
                  end else begin
`ifdef MUL_EARLY_OUT_EN
                     r_alu_req <= (r_mrem[XLEN-1:1] != '0);
`else
                     r_alu_req <= 1'b1;
`endif
                  end
               end
            end

            DONE: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
//------------------------------------------------------------------------------
// Module : tb_alu_mul_seq
// Brief  : Directed self-checking bench for alu_mul_seq with a behavioural ALU.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_mul_seq;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [31:0] i_req_a;
   logic [31:0] i_req_b;
   logic        i_req_hi;
   logic        o_alu_req;
   logic        i_alu_gnt;
   logic [31:0] o_alu_in1;
   logic [31:0] o_alu_in2;
   logic [3:0]  o_alu_ctrl;
   logic [31:0] i_alu_out;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_data;

   int n_total = 0;
   int n_bad   = 0;

   always #5 i_clk = ~i_clk;

   // Shared-ALU stand-in: the pipeline's adder, combinational.
   assign i_alu_out = (o_alu_ctrl == 4'b0010) ? (o_alu_in1 + o_alu_in2) : 32'hDEAD_0000;

   alu_mul_seq dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_a     (i_req_a),
      .i_req_b     (i_req_b),
      .i_req_hi    (i_req_hi),
      .o_alu_req   (o_alu_req),
      .i_alu_gnt   (i_alu_gnt),
      .o_alu_in1   (o_alu_in1),
      .o_alu_in2   (o_alu_in2),
      .o_alu_ctrl  (o_alu_ctrl),
      .i_alu_out   (i_alu_out),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_data  (o_rsp_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Issues one request and follows it to completion with i_rsp_ready held high.
   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic hi, input bit toggle, input logic [31:0] exp_data,
                          input int exp_done, input int exp_alu);
      int          cyc;
      int          done_cyc;
      int          rdy_rise;
      int          alu_cycles;
      int          frozen_bad;
      bit          stalled;
      logic [31:0] prev_in2;
      cyc        = 0;
      done_cyc   = -1;
      rdy_rise   = -1;
      alu_cycles = 0;
      frozen_bad = 0;
      i_req_valid = 1'b1;
      i_req_a     = a;
      i_req_b     = b;
      i_req_hi    = hi;
      i_rsp_ready = 1'b1;
      while (rdy_rise < 0 && cyc < 300) begin
         stalled   = toggle && (cyc > 0) && (cyc % 2 == 0);
         i_alu_gnt = !stalled;
         prev_in2  = o_alu_in2;
         tick();
         cyc++;
         i_req_valid = 1'b0;
         i_req_a     = 32'h5A5A_5A5A;
         i_req_b     = 32'hA5A5_A5A5;
         if (cyc == 1) chk({tag, "_in1"}, 64'(o_alu_in1), 64'(a));
         if (stalled && done_cyc < 0 && o_alu_in2 !== prev_in2) frozen_bad++;
         if (o_alu_req) alu_cycles++;
         if (o_rsp_valid && done_cyc < 0) begin
            done_cyc = cyc;
            chk({tag, "_data"}, 64'(o_rsp_data), 64'(exp_data));
         end
         if (o_req_ready && rdy_rise < 0) rdy_rise = cyc;
      end
      i_alu_gnt = 1'b1;
      chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
      chk({tag, "_ready_cyc"}, 64'(rdy_rise), 64'(exp_done + 2));
      chk({tag, "_alu_cycles"}, 64'(alu_cycles), 64'(exp_alu));
      if (toggle) chk({tag, "_stall_frozen"}, 64'(frozen_bad), 64'(0));
   endtask

   initial begin : main
      int          unstable;
      int          cyc;
      logic [31:0] hold;

      i_rst       = 1'b1;
      i_req_valid = 1'b0;
      i_req_a     = '0;
      i_req_b     = '0;
      i_req_hi    = 1'b0;
      i_alu_gnt   = 1'b1;
      i_rsp_ready = 1'b0;
      tick();
      tick();
      chk("rst_req_ready", 64'(o_req_ready), 64'(1));
      chk("rst_alu_req",   64'(o_alu_req),   64'(0));
      chk("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
      chk("rst_rsp_data",  64'(o_rsp_data),  64'(0));
      chk("rst_alu_ctrl",  64'(o_alu_ctrl),  64'(4'b0010));
      i_rst = 1'b0;
      tick();

`ifdef MUL_EARLY_OUT_EN
      run_mul("t1_3x5", 32'd3, 32'd5, 1'b0, 1'b0, 32'h0000_000F, 5, 3);
`else
      run_mul("t1_3x5", 32'd3, 32'd5, 1'b0, 1'b0, 32'h0000_000F, 33, 32);
`endif
      run_mul("t2_max_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFE, 33, 32);
      run_mul("t2_max_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0001, 33, 32);
      run_mul("t3_toggle", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, 32'h0B00_EA4E, 64, 63);

      // Response back-pressure: result must hold and new requests must be ignored.
      i_req_valid = 1'b1;
      i_req_a     = 32'h0001_0000;
      i_req_b     = 32'h0001_0000;
      i_req_hi    = 1'b1;
      i_rsp_ready = 1'b0;
      tick();
      i_req_valid = 1'b0;
      cyc = 1;
      while (!o_rsp_valid && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("t4_valid", 64'(o_rsp_valid), 64'(1));
      chk("t4_data",  64'(o_rsp_data),  64'(1));
      hold        = o_rsp_data;
      unstable    = 0;
      i_req_valid = 1'b1;
      i_req_a     = 32'd9;
      i_req_b     = 32'd9;
      repeat (10) begin
         tick();
         if (!o_rsp_valid || o_rsp_data !== hold || o_req_ready || o_alu_req) unstable++;
      end
      chk("t4_hold_stable", 64'(unstable), 64'(0));
      i_req_valid = 1'b0;
      i_rsp_ready = 1'b1;
      tick();
      chk("t4_valid_drop", 64'(o_rsp_valid), 64'(0));
      chk("t4_ready_lag",  64'(o_req_ready), 64'(0));
      tick();
      chk("t4_ready_back", 64'(o_req_ready), 64'(1));

      // Abort mid-run with reset.
      i_req_valid = 1'b1;
      i_req_a     = 32'h0000_FFFF;
      i_req_b     = 32'h0000_FFFF;
      i_req_hi    = 1'b0;
      tick();
      i_req_valid = 1'b0;
      repeat (15) tick();
      chk("t5_busy", 64'(o_alu_req), 64'(1));
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("t5_rst_ready", 64'(o_req_ready), 64'(1));
      chk("t5_rst_valid", 64'(o_rsp_valid), 64'(0));
      chk("t5_rst_alu",   64'(o_alu_req),   64'(0));
      chk("t5_rst_data",  64'(o_rsp_data),  64'(0));
`ifdef MUL_EARLY_OUT_EN
      run_mul("t5_7x6", 32'd7, 32'd6, 1'b0, 1'b0, 32'd42, 5, 3);
      run_mul("t6_b0",  32'h1357_9BDF, 32'd0, 1'b0, 1'b0, 32'd0, 2, 0);
      run_mul("t6_b1",  32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0, 32'hDEAD_BEEF, 3, 1);
`else
      run_mul("t5_7x6", 32'd7, 32'd6, 1'b0, 1'b0, 32'd42, 33, 32);
      run_mul("t6_b0",  32'h1357_9BDF, 32'd0, 1'b0, 1'b0, 32'd0, 33, 32);
      run_mul("t6_b1",  32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0, 32'hDEAD_BEEF, 33, 32);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
